// File: rtl/id_ex_reg_pkg.sv
// Shared constants for the ID/EX pipeline register: ALU function codes,
// operand-select encodings, the bubble (NOP) control word and the forwarding
// match helper used by both forwarding muxes.
package id_ex_reg_pkg;

  // ALU function codes carried through EX
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_SLL  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_SLT  = 5'd8;
  localparam logic [4:0] ALU_SLTU = 5'd9;

  // Operand 1 select: forwarded rs1, the instruction PC, or zero
  localparam logic [1:0] OP1_RS1   = 2'd0;
  localparam logic [1:0] OP1_PC    = 2'd1;
  localparam logic [1:0] OP1_ZERO  = 2'd2;
  localparam logic [1:0] OP1_ZERO3 = 2'd3;

  // Operand 2 select: forwarded rs2, immediate, constant 4 (link address), or zero
  localparam logic [1:0] OP2_RS2  = 2'd0;
  localparam logic [1:0] OP2_IMM  = 2'd1;
  localparam logic [1:0] OP2_FOUR = 2'd2;
  localparam logic [1:0] OP2_ZERO = 2'd3;

  // Control portion of the EX register (everything that is not XLEN wide)
  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [4:0] alu_fn;
    logic [1:0] op1_sel;
    logic [1:0] op2_sel;
    logic       wb_en;
    logic       mem_ren;
    logic       mem_wen;
  } ex_ctrl_t;

  // The single definition of a bubble; reset and the kill paths both load it.
  // A bubble's data fields (pc, rs1/rs2 data, imm) are all zero.
  localparam ex_ctrl_t BUBBLE_CTRL = '{
    valid:   1'b0,
    rs1:     5'd0,
    rs2:     5'd0,
    rd:      5'd0,
    alu_fn:  ALU_ADD,
    op1_sel: OP1_RS1,
    op2_sel: OP2_RS2,
    wb_en:   1'b0,
    mem_ren: 1'b0,
    mem_wen: 1'b0
  };

  // What the EX register does on the coming edge
  typedef enum logic [1:0] {
    EX_LOAD,
    EX_BUBBLE,
    EX_HOLD
  } ex_action_e;

  // A later stage can supply a source operand only if it really writes a
  // non-x0 register that matches the source address.
  function automatic logic fwd_hit(input logic       valid,
                                   input logic       wb_en,
                                   input logic [4:0] rd,
                                   input logic [4:0] src);
    return valid & wb_en & (rd != 5'd0) & (rd == src);
  endfunction

endpackage

// File: rtl/id_ex_reg_fwd_mux.sv
// Operand forwarding mux: picks the youngest in-flight result that targets
// the given source register, falling back to the value read in ID.
module fwd_mux
  import id_ex_reg_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      src_addr_i,
  input  logic [XLEN-1:0] reg_data_i,
  input  logic            mem_valid_i,
  input  logic            mem_wb_en_i,
  input  logic [4:0]      mem_rd_i,
  input  logic [XLEN-1:0] mem_data_i,
  input  logic            wb_valid_i,
  input  logic            wb_wb_en_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic [XLEN-1:0] fwd_data_o
);

  // EX/MEM is younger than MEM/WB, so its match wins; x0 never matches
  always_comb begin
    fwd_data_o = reg_data_i;
    if (fwd_hit(mem_valid_i, mem_wb_en_i, mem_rd_i, src_addr_i)) begin
      fwd_data_o = mem_data_i;
    end else if (fwd_hit(wb_valid_i, wb_wb_en_i, wb_rd_i, src_addr_i)) begin
      fwd_data_o = wb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush/stall handling, load-use hazard
// detection, and combinational operand forwarding on the registered
// instruction so a stalled instruction still sees newly produced results.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [4:0]      id_alu_fn,
  input  logic [1:0]      id_op1_sel,
  input  logic [1:0]      id_op2_sel,
  input  logic            id_wb_en,
  input  logic            id_mem_ren,
  input  logic            id_mem_wen,
  input  logic            stall,
  input  logic            flush,
  input  logic            mem_valid,
  input  logic            mem_wb_en,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_valid,
  input  logic            wb_wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_alu_fn,
  output logic [XLEN-1:0] ex_src1,
  output logic [XLEN-1:0] ex_src2,
  output logic [XLEN-1:0] ex_store_data,
  output logic [4:0]      ex_rd,
  output logic            ex_wb_en,
  output logic            ex_mem_ren,
  output logic            ex_mem_wen,
  output logic            load_use_hazard
);

  ex_ctrl_t        ctrl_q, ctrl_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [XLEN-1:0] imm_q, imm_d;

  ex_ctrl_t        id_ctrl;
  ex_action_e      action;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // Pack the decoded ID control fields into the EX control word layout
  always_comb begin
    id_ctrl         = BUBBLE_CTRL;
    id_ctrl.valid   = id_valid;
    id_ctrl.rs1     = id_rs1;
    id_ctrl.rs2     = id_rs2;
    id_ctrl.rd      = id_rd;
    id_ctrl.alu_fn  = id_alu_fn;
    id_ctrl.op1_sel = id_op1_sel;
    id_ctrl.op2_sel = id_op2_sel;
    id_ctrl.wb_en   = id_wb_en;
    id_ctrl.mem_ren = id_mem_ren;
    id_ctrl.mem_wen = id_mem_wen;
  end

  // A load in EX whose result the ID instruction needs cannot be forwarded in time
  always_comb begin
    load_use_hazard = ctrl_q.valid & ctrl_q.mem_ren & (ctrl_q.rd != 5'd0) & id_valid &
                      ((ctrl_q.rd == id_rs1) | (ctrl_q.rd == id_rs2));
  end

  // Decide the register's action: a kill beats a freeze, which beats a hazard bubble
  always_comb begin
    action = EX_LOAD;
    if (flush) begin
      action = EX_BUBBLE;
    end else if (stall) begin
      action = EX_HOLD;
    end else if (load_use_hazard) begin
      action = EX_BUBBLE;
    end
  end

  // Next-state values for every field of the EX register
  always_comb begin
    ctrl_d     = ctrl_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    case (action)
      EX_LOAD: begin
        ctrl_d     = id_ctrl;
        pc_d       = id_pc;
        rs1_data_d = id_rs1_data;
        rs2_data_d = id_rs2_data;
        imm_d      = id_imm;
      end
      EX_BUBBLE: begin
        ctrl_d     = BUBBLE_CTRL;
        pc_d       = '0;
        rs1_data_d = '0;
        rs2_data_d = '0;
        imm_d      = '0;
      end
      default: begin
        ctrl_d     = ctrl_q;
      end
    endcase
  end

  // EX register; reset forces the bubble regardless of stall or flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q     <= BUBBLE_CTRL;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
    end
  end

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
    .src_addr_i  (ctrl_q.rs1),
    .reg_data_i  (rs1_data_q),
    .mem_valid_i (mem_valid),
    .mem_wb_en_i (mem_wb_en),
    .mem_rd_i    (mem_rd),
    .mem_data_i  (mem_data),
    .wb_valid_i  (wb_valid),
    .wb_wb_en_i  (wb_wb_en),
    .wb_rd_i     (wb_rd),
    .wb_data_i   (wb_data),
    .fwd_data_o  (fwd_rs1)
  );

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
    .src_addr_i  (ctrl_q.rs2),
    .reg_data_i  (rs2_data_q),
    .mem_valid_i (mem_valid),
    .mem_wb_en_i (mem_wb_en),
    .mem_rd_i    (mem_rd),
    .mem_data_i  (mem_data),
    .wb_valid_i  (wb_valid),
    .wb_wb_en_i  (wb_wb_en),
    .wb_rd_i     (wb_rd),
    .wb_data_i   (wb_data),
    .fwd_data_o  (fwd_rs2)
  );

  // ALU operand 1 select
  always_comb begin
    ex_src1 = '0;
    case (ctrl_q.op1_sel)
      OP1_RS1: ex_src1 = fwd_rs1;
      OP1_PC:  ex_src1 = pc_q;
      default: ex_src1 = '0;
    endcase
  end

  // ALU operand 2 select; constant 4 gives the link address for jumps
  always_comb begin
    ex_src2 = '0;
    case (ctrl_q.op2_sel)
      OP2_RS2:  ex_src2 = fwd_rs2;
      OP2_IMM:  ex_src2 = imm_q;
      OP2_FOUR: ex_src2 = XLEN'(32'd4);
      default:  ex_src2 = '0;
    endcase
  end

  // Store data always uses the forwarded rs2, independent of the ALU operand choice
  always_comb begin
    ex_store_data = fwd_rs2;
  end

  // Drive the registered control fields straight out to EX
  always_comb begin
    ex_valid   = ctrl_q.valid;
    ex_pc      = pc_q;
    ex_alu_fn  = ctrl_q.alu_fn;
    ex_rd      = ctrl_q.rd;
    ex_wb_en   = ctrl_q.wb_en;
    ex_mem_ren = ctrl_q.mem_ren;
    ex_mem_wen = ctrl_q.mem_wen;
  end

endmodule
